// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite-DMA block: fixed register addresses,
// controller states and the trigger decode.
package oam_dma_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_e;

  function automatic logic is_dma_trigger(input logic we, input logic [15:0] addr);
    return we && (addr == ADDR_OAMDMA);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA bus arbiter: stalls the CPU after a $4014 write and copies one
// 256-byte page to OAMDATA, otherwise passes the CPU bus straight through.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  dma_state_e state_reg, state_next;
  logic [7:0] page_reg, page_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] data_reg, data_next;
  logic       phase_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
      data_reg  <= 8'h00;
      phase_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      phase_reg <= ~phase_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    bus_addr   = cpu_addr;
    bus_dout   = cpu_dout;
    bus_we     = cpu_we;

    case (state_reg)
      ST_IDLE: begin
        if (is_dma_trigger(cpu_we, cpu_addr)) begin
          page_next  = cpu_dout;
          idx_next   = 8'h00;
          state_next = ST_HALT;
        end
      end

      // CPU still owns the bus; writes are never halted, so wait for a read
      ST_HALT: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        if (cpu_we) begin
          if (is_dma_trigger(cpu_we, cpu_addr)) begin
            page_next = cpu_dout;
          end
        end else begin
          state_next = phase_reg ? ST_READ : ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = 16'h0000;
        bus_dout   = data_reg;
        bus_we     = 1'b0;
        state_next = ST_READ;
      end

      ST_READ: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = {page_reg, idx_reg};
        bus_dout   = data_reg;
        bus_we     = 1'b0;
        data_next  = bus_din;
        state_next = ST_WRITE;
      end

      ST_WRITE: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = ADDR_OAMDATA;
        bus_dout   = data_reg;
        bus_we     = 1'b1;
        idx_next   = idx_reg + 8'h01;
        state_next = (idx_reg == 8'hFF) ? ST_IDLE : ST_READ;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues the expected $2004 writes,
// a negedge monitor pops and checks them against the observed bus.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        dma_active;

  typedef struct packed {
    logic [15:0] src;
    logic [7:0]  data;
  } oam_exp_t;

  oam_exp_t    exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          oam_writes = 0;
  bit          tb_phase;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_we = 1'b0;
  logic [15:0] extra_addr[2];
  logic [7:0]  extra_data[2];

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_we     (bus_we),
    .bus_din    (bus_din),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // RAM model: every location holds its low address byte xor A5h
  assign bus_din = bus_addr[7:0] ^ 8'hA5;

  always @(posedge clk or posedge reset) begin
    if (reset) tb_phase <= 1'b0;
    else       tb_phase <= ~tb_phase;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_we && bus_addr == 16'h2004 && dma_active && !cpu_rdy) begin
        oam_writes++;
        if (exp_q.size() == 0) begin
          check("oam_unexpected_write", 32'(bus_dout), 32'h1FF);
        end else begin
          oam_exp_t e;
          e = exp_q.pop_front();
          check("oam_src_addr", 32'(prev_addr), 32'(e.src));
          check("oam_read_we", 32'(prev_we), 0);
          check("oam_data", 32'(bus_dout), 32'(e.data));
          check("oam_write_phase", 32'(tb_phase), 1);
        end
        $display("oam write #%0d src=%04h data=%02h", oam_writes, prev_addr, bus_dout);
      end
      prev_addr = bus_addr;
      prev_we   = bus_we;
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic we, input bit chk);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = we;
    @(negedge clk);
    if (chk) begin
      check("idle_addr", 32'(bus_addr), 32'(a));
      check("idle_we", 32'(bus_we), 32'(we));
      if (we) check("idle_dout", 32'(bus_dout), 32'(d));
      check("idle_rdy", 32'(cpu_rdy), 1);
      check("idle_active", 32'(dma_active), 0);
      $display("cpu %s addr=%04h data=%02h rdy=%0b", we ? "wr" : "rd", a, d, cpu_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  // Trigger with page pg so that cycle T+1 has phase t1_phase, then issue
  // n_extra halt-cycle writes from extra_addr/extra_data before reading.
  task automatic run_dma(input logic [7:0] pg, input bit t1_phase, input int n_extra,
                         input bit wait_done);
    logic [7:0] final_pg;
    logic [7:0] idx8;
    int         stall;
    int         base;
    int         exp_stall;
    bit         dummy_phase;

    while (tb_phase == t1_phase) cpu_cycle(16'h8000, 8'h00, 1'b0, 1'b0);

    final_pg = pg;
    for (int k = 0; k < n_extra; k++)
      if (extra_addr[k] == 16'h4014) final_pg = extra_data[k];
    for (int i = 0; i < 256; i++) begin
      idx8 = 8'(i);
      exp_q.push_back({final_pg, idx8, idx8 ^ 8'hA5});
    end
    base = oam_writes;

    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_we   = 1'b1;
    @(negedge clk);
    check("trig_bus_addr", 32'(bus_addr), 32'h4014);
    check("trig_bus_we", 32'(bus_we), 1);
    check("trig_rdy", 32'(cpu_rdy), 1);
    $display("trigger page=%02h t1_phase=%0b extra=%0d", pg, t1_phase, n_extra);
    @(posedge clk);
    #1;

    stall = 0;
    for (int k = 0; k < n_extra; k++) begin
      cpu_addr = extra_addr[k];
      cpu_dout = extra_data[k];
      cpu_we   = 1'b1;
      @(negedge clk);
      check("halt_rdy", 32'(cpu_rdy), 0);
      check("halt_active", 32'(dma_active), 1);
      check("halt_addr", 32'(bus_addr), 32'(extra_addr[k]));
      check("halt_dout", 32'(bus_dout), 32'(extra_data[k]));
      check("halt_we", 32'(bus_we), 1);
      $display("halt write addr=%04h data=%02h", extra_addr[k], extra_data[k]);
      stall++;
      @(posedge clk);
      #1;
    end

    dummy_phase = tb_phase;
    cpu_addr = 16'h8000;
    cpu_dout = 8'h00;
    cpu_we   = 1'b0;
    if (!wait_done) return;

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cpu_rdy) break;
      stall++;
      @(posedge clk);
      #1;
    end
    exp_stall = (dummy_phase ? 513 : 514) + n_extra;
    check("stall_timeout", 32'(cpu_rdy), 1);
    check("stall_cycles", 32'(stall), 32'(exp_stall));
    check("done_active", 32'(dma_active), 0);
    check("done_bus_addr", 32'(bus_addr), 32'h8000);
    check("done_write_count", 32'(oam_writes - base), 256);
    check("done_queue_empty", 32'(exp_q.size()), 0);
    $display("dma done page=%02h stall=%0d expected=%0d", final_pg, stall, exp_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    cpu_addr = 16'h1234;
    cpu_dout = 8'h3C;
    cpu_we   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", 32'(cpu_rdy), 1);
    check("reset_active", 32'(dma_active), 0);
    check("reset_bus_addr", 32'(bus_addr), 32'h1234);
    $display("reset rdy=%0b active=%0b", cpu_rdy, dma_active);
    @(posedge clk);
    #1;
    reset = 1'b0;

    cpu_cycle(16'h8000, 8'h00, 1'b0, 1'b1);
    cpu_cycle(16'h0010, 8'h55, 1'b1, 1'b1);

    run_dma(8'h02, 1'b1, 0, 1'b1);
    run_dma(8'h02, 1'b0, 0, 1'b1);

    extra_addr[0] = 16'h0100; extra_data[0] = 8'hAA;
    extra_addr[1] = 16'h4014; extra_data[1] = 8'h07;
    run_dma(8'h05, 1'b1, 2, 1'b1);

    // Abort after 128 copies; nothing more may reach $2004
    base = oam_writes;
    run_dma(8'h04, 1'b1, 0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      if (oam_writes - base >= 128) break;
    end
    check("abort_progress", 32'(oam_writes - base), 128);
    reset = 1'b1;
    #1;
    check("abort_rdy", 32'(cpu_rdy), 1);
    check("abort_active", 32'(dma_active), 0);
    check("abort_bus_addr", 32'(bus_addr), 32'h8000);
    $display("abort at idx 80h rdy=%0b active=%0b", cpu_rdy, dma_active);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) cpu_cycle(16'h8000, 8'h00, 1'b0, 1'b0);
    check("abort_no_more_writes", 32'(oam_writes - base), 128);
    run_dma(8'h03, 1'b1, 0, 1'b1);

    run_dma(8'hFF, 1'b1, 0, 1'b1);
    cpu_cycle(16'h8001, 8'h00, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
